// File: rtl/spdif_dit.sv
// spdif_dit: S/PDIF (IEC 60958) transmitter producing B/M/W-preambled, biphase-mark subframes.
// Optional build macro SPDIF_DIT_HOLD_ON_UNDERRUN_EN: on underrun repeat the channel's last sample with V=0.
module spdif_dit #(
  parameter int MAX_CLK_PER_HALFBIT_LOG2 = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [MAX_CLK_PER_HALFBIT_LOG2-1:0] clk_per_halfbit,
  input  logic [23:0]                         data_i,
  input  logic                                valid_i,
  output logic                                ready_o,
  input  logic [191:0]                        udata_i,
  input  logic [191:0]                        cdata_i,
  output logic                                signal_o,
  output logic                                lrck_o,
  output logic                                block_start_o
);
  localparam int N = MAX_CLK_PER_HALFBIT_LOG2;
  localparam logic [7:0] PRE_B = 8'b00010111;
  localparam logic [7:0] PRE_M = 8'b00011101;
  localparam logic [7:0] PRE_W = 8'b00011011;

  logic [N-1:0]   r_cnt;
  logic [N-1:0]   r_cph;
  logic [5:0]     r_hb;
  logic [7:0]     r_frame;
  logic           r_right;
  logic [7:0]     r_pre_lv;
  logic [27:0]    r_sf;
  logic [23:0]    r_hold;
  logic [191:0]   r_udata;
  logic [191:0]   r_cdata;
`ifdef SPDIF_DIT_HOLD_ON_UNDERRUN_EN
  logic [23:0]    r_last_l;
  logic [23:0]    r_last_r;
`endif

  logic [N-1:0]   w_cph;
  logic           w_tick;
  logic           w_load;
  logic           w_xfer;
  logic           w_blk;
  logic [7:0]     w_pre;
  logic [7:0]     w_pre_lv;
  logic [7:0]     w_uidx;
  logic           w_u;
  logic           w_c;
  logic           w_v;
  logic [23:0]    w_aud;
  logic [4:0]     w_slot;
  logic [27:0]    w_word;

  // Halfbit timing, preamble selection and next-subframe word assembly.
  always_comb begin
    // The halfbit length is taken from the input only on the first clk of each halfbit.
    w_cph    = (r_cnt == '0) ? clk_per_halfbit : r_cph;
    w_tick   = (w_cph >= N'(2)) && (r_cnt == w_cph - N'(1));
    w_load   = w_tick && (r_hb == 6'd0);
    w_xfer   = valid_i && ready_o;
    w_blk    = !r_right && (r_frame == 8'd0);
    if (r_right) begin
      w_pre = PRE_W;
    end else if (w_blk) begin
      w_pre = PRE_B;
    end else begin
      w_pre = PRE_M;
    end
    w_pre_lv = signal_o ? w_pre : ~w_pre;
    w_uidx   = 8'd191 - r_frame;
    if (w_blk) begin
      w_u = udata_i[w_uidx];
      w_c = cdata_i[w_uidx];
    end else begin
      w_u = r_udata[w_uidx];
      w_c = r_cdata[w_uidx];
    end
    if (!ready_o) begin
      w_aud = r_hold;
      w_v   = 1'b0;
    end else begin
`ifdef SPDIF_DIT_HOLD_ON_UNDERRUN_EN
      w_aud = r_right ? r_last_r : r_last_l;
      w_v   = 1'b0;
`else
      w_aud = 24'd0;
      w_v   = 1'b1;
`endif
    end
    w_word = {^{w_c, w_u, w_v, w_aud}, w_c, w_u, w_v, w_aud};
    w_slot = r_hb[5:1] - 5'd4;
  end

  // Halfbit timer; a length below 2 parks it at zero so the input is re-sampled each clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_cph <= '0;
    end else begin
      r_cph <= w_cph;
      if (w_tick) begin
        r_cnt <= '0;
      end else if (w_cph >= N'(2)) begin
        r_cnt <= r_cnt + N'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Subframe sequencer and BMC line driver.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      signal_o      <= 1'b0;
      lrck_o        <= 1'b0;
      block_start_o <= 1'b0;
      r_hb          <= 6'd0;
      r_frame       <= 8'd0;
      r_right       <= 1'b0;
      r_pre_lv      <= 8'd0;
      r_sf          <= 28'd0;
      r_udata       <= 192'd0;
      r_cdata       <= 192'd0;
`ifdef SPDIF_DIT_HOLD_ON_UNDERRUN_EN
      r_last_l      <= 24'd0;
      r_last_r      <= 24'd0;
`endif
    end else begin
      block_start_o <= 1'b0;
      if (w_tick) begin
        r_hb <= r_hb + 6'd1;
        if (w_load) begin
          signal_o      <= w_pre_lv[7];
          r_pre_lv      <= w_pre_lv;
          r_sf          <= w_word;
          lrck_o        <= r_right;
          block_start_o <= w_blk;
          r_right       <= ~r_right;
          if (w_blk) begin
            r_udata <= udata_i;
            r_cdata <= cdata_i;
          end
          if (r_right) begin
            r_frame <= (r_frame == 8'd191) ? 8'd0 : r_frame + 8'd1;
          end
`ifdef SPDIF_DIT_HOLD_ON_UNDERRUN_EN
          if (r_right) begin
            r_last_r <= w_aud;
          end else begin
            r_last_l <= w_aud;
          end
`endif
        end else if (r_hb < 6'd8) begin
          signal_o <= r_pre_lv[3'd7 - r_hb[2:0]];
        end else if (!r_hb[0]) begin
          signal_o <= ~signal_o;
        end else begin
          signal_o <= signal_o ^ r_sf[w_slot];
        end
      end
    end
  end

  // Holding register handshake; a word accepted on a load clk waits for the next subframe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_o <= 1'b1;
      r_hold  <= 24'd0;
    end else begin
      if (w_xfer) begin
        r_hold <= data_i;
      end
      if (w_load) begin
        ready_o <= !w_xfer;
      end else if (w_xfer) begin
        ready_o <= 1'b0;
      end
    end
  end
endmodule
